keypad_entry: RTL

- PIN-entry front end that sits directly upstream of the siren alarm FSM and drives its 4-bit keypad input.
- Collects single-cycle key strobes from the scanned keypad and checks a 4-digit PIN.
- On a correct PIN followed by ARM or DISARM, presents the siren's arm code (0011) or disarm code (1100) for a fixed number of enabled cycles; otherwise keypad rests at 0000.
- Adds entry timeout, wrong-PIN counting and lockout; shares the ENA tick with the siren.

---
 rtl/keypad_entry.sv | 139 +++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// PIN-entry front end for the siren alarm FSM: collects keypad digits, checks a
// 4-digit PIN and drives the siren's arm/disarm code, with timeout and lockout.
module keypad_entry #(
  parameter logic [15:0] PIN           = 16'h1234,
  parameter int unsigned HOLD_TICKS    = 4,
  parameter int unsigned TIMEOUT_TICKS = 32,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCKOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] keypad,
  output logic       is_locked,
  output logic [2:0] digit_count,
  output logic       entry_error
);

  localparam int unsigned T_MAX0 = (HOLD_TICKS > TIMEOUT_TICKS) ? HOLD_TICKS : TIMEOUT_TICKS;
  localparam int unsigned T_MAX  = (T_MAX0 > LOCKOUT_TICKS) ? T_MAX0 : LOCKOUT_TICKS;
  localparam int unsigned TW     = $clog2(T_MAX + 1);
  localparam int unsigned FW     = $clog2(MAX_FAILS + 1);

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [3:0] CODE_ARM    = 4'b0011;
  localparam logic [3:0] CODE_DISARM = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD,
    LOCKOUT
  } state_t;

  state_t        state;
  logic [15:0]   buffer;
  logic [FW-1:0] fail_cnt;
  // One down-counter serves all three timed phases; only one is ever active.
  logic [TW-1:0] timer;

  logic is_digit, is_cmd, pin_ok, fail_last, timer_last;

  always_comb begin
    is_digit   = (key_code <= 4'd9);
    is_cmd     = (key_code == KEY_ARM) || (key_code == KEY_DISARM);
    pin_ok     = (digit_count == 3'd4) && (buffer == PIN);
    fail_last  = (fail_cnt == FW'(MAX_FAILS - 1));
    timer_last = (timer <= TW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      buffer      <= '0;
      fail_cnt    <= '0;
      timer       <= '0;
      keypad      <= '0;
      is_locked   <= 1'b0;
      digit_count <= '0;
      entry_error <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (key_valid) begin
            if (is_digit) begin
              if (digit_count != 3'd4) begin
                buffer      <= {buffer[11:0], key_code};
                digit_count <= digit_count + 3'd1;
              end
              state <= COLLECT;
              timer <= TW'(TIMEOUT_TICKS);
            end else if (key_code == KEY_CLEAR) begin
              buffer      <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end else if (is_cmd) begin
              buffer      <= '0;
              digit_count <= '0;
              if (pin_ok) begin
                keypad   <= (key_code == KEY_ARM) ? CODE_ARM : CODE_DISARM;
                fail_cnt <= '0;
                state    <= HOLD;
                timer    <= TW'(HOLD_TICKS);
              end else begin
                entry_error <= 1'b1;
                if (fail_last) begin
                  fail_cnt  <= '0;
                  is_locked <= 1'b1;
                  state     <= LOCKOUT;
                  timer     <= TW'(LOCKOUT_TICKS);
                end else begin
                  fail_cnt <= fail_cnt + 1'b1;
                  state    <= IDLE;
                end
              end
            end else begin
              timer <= TW'(TIMEOUT_TICKS);
            end
          end else if (state == COLLECT && ENA) begin
            if (timer_last) begin
              buffer      <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        HOLD: begin
          if (ENA) begin
            if (timer_last) begin
              keypad <= '0;
              state  <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (ENA) begin
            if (timer_last) begin
              is_locked <= 1'b0;
              state     <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
